ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The parameter aw SHALL default to 8 and set the instruction memory address width.
REQ-002 The parameter dw SHALL default to 16 and set the instruction word width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  the synchronous, active-high reset.
REQ-006 addr  output  aw  the memory read address; equals pc.
REQ-007 rex  output  1  the memory read enable, active-low; 0 means a fetch this cycle.
REQ-008 rdata  input  dw  the memory read data; combinational, valid in the same cycle as addr/rex.
REQ-009 instr  output  dw  the instruction word at the buffer head.
REQ-010 iaddr  output  aw  the fetch address of instr.
REQ-011 ivalid  output  1  high when the buffer is non-empty.
REQ-012 iready  input  1  the consumer accept signal; an instruction transfers when ivalid and iready are both high.
REQ-013 jmp  input  1  the redirect request.
REQ-014 jaddr  input  aw  the redirect target.
REQ-015 halted  output  1  the fetch-stopped flag.

Function
REQ-016 The block SHALL hold an aw-bit pc and a 2-entry FIFO of {address, word} pairs with a 2-bit count.
REQ-017 fetch is defined as (count<2) and not jmp and not halted and not rst; rex SHALL be the inverse of fetch, combinationally.
REQ-018 On a fetch cycle, the block SHALL push {pc, rdata} at the clock edge and set pc to pc+1, wrapping from 2^aw-1 to 0 with no flag.
REQ-019 A pop (ivalid and iready) SHALL remove the head at the clock edge; push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-020 With count==2, no fetch SHALL occur even if a pop happens that cycle; rex=1.
REQ-021 Latency: a word addressed in cycle N SHALL appear on instr with ivalid=1 in cycle N+1 at the earliest.
REQ-022 jmp=1 SHALL suppress fetch that cycle, load pc<=jaddr, set count<=0 and clear halted; an instruction popped in the jmp cycle counts as consumed, and all other entries are discarded.
REQ-023 ivalid, instr and iaddr SHALL depend only on registered state, with no combinational path from iready or jmp.
REQ-024 With count==0, instr and iaddr SHALL hold their last values; consumers SHALL qualify them with ivalid.

Reset
REQ-025 rst=1 SHALL set pc=0, count=0 and halted=0 at the next edge, and rex SHALL be 1 throughout the rst cycle.
REQ-026 rst SHALL take priority over jmp, fetch and pop, including when asserted mid-stream; buffered entries SHALL be discarded.
REQ-027 After the edge where rst deasserts, the first fetch SHALL be at addr=0, and ivalid SHALL rise one cycle later.

Configuration
REQ-028 With IFETCH_HALT_EN defined, a pushed word equal to {dw{1'b1}} SHALL be buffered normally and set halted=1 at the same edge; halted SHALL then block further fetches until jmp or rst.
REQ-029 Without IFETCH_HALT_EN, halted SHALL be tied to 0, and the all-ones word SHALL be treated as an ordinary instruction.

Verification
REQ-030 Reset then free-run: mem[i]=i, iready=1 -> after rst deasserts, instr/iaddr sequence 0,1,2,... one per cycle from the second cycle, and rex=0 every cycle.
REQ-031 Back-pressure: iready=0 for 5 cycles -> count saturates at 2, rex=1, pc frozen at 2; on iready=1, words 0,1,2 follow with no loss or duplication.
REQ-032 Wrap: jmp with jaddr=8'hFE, iready=1 -> iaddr sequence FE, FF, 00, 01.
REQ-033 Redirect mid-stream: count==2 holding addresses 5 and 6, jmp=1 with jaddr=8'h40 and iready=1 -> word 5 consumed, 6 discarded, next ivalid shows iaddr=40 two cycles after the jmp edge.
REQ-034 Reset mid-operation: rst=1 for one cycle with count==2 -> ivalid=0 next cycle and the next fetch at addr=0.
REQ-035 IFETCH_HALT_EN defined, mem[3]=16'hFFFF -> halted=1 after the word at address 3 is pushed, no fetch after address 3, and jmp to 0 resumes fetching; with the macro undefined, fetch continues to address 4.

Source files
------------

// File: rtl/ifetch_if.sv
// ----------------------------------------------------------------------------
// ifetch_if -- signal bundle between the instruction fetch unit and its
// surroundings (instruction memory read port, consumer stream, redirect).
//
// Parameters
//   aw : instruction memory address width
//   dw : instruction word width
//
// Signals
//   addr   : memory read address (the fetch pc)
//   rex    : memory read enable, active-low (0 = fetch this cycle)
//   rdata  : memory read data, combinational from addr
//   instr  : instruction word at the buffer head
//   iaddr  : fetch address of instr
//   ivalid : buffer non-empty
//   iready : consumer accept
//   jmp    : redirect request
//   jaddr  : redirect target
//   halted : fetch-stopped flag
//
// Modports
//   master : the fetch unit side
//   slave  : the environment side (memory, consumer, redirect source)
// ----------------------------------------------------------------------------
interface ifetch_if #(
    parameter int aw = 8,
    parameter int dw = 16
);
    logic [aw-1:0] addr;
    logic          rex;
    logic [dw-1:0] rdata;
    logic [dw-1:0] instr;
    logic [aw-1:0] iaddr;
    logic          ivalid;
    logic          iready;
    logic          jmp;
    logic [aw-1:0] jaddr;
    logic          halted;

    modport master (
        output addr, rex, instr, iaddr, ivalid, halted,
        input  rdata, iready, jmp, jaddr
    );

    modport slave (
        input  addr, rex, instr, iaddr, ivalid, halted,
        output rdata, iready, jmp, jaddr
    );
endinterface

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch -- instruction fetch unit with a 2-entry prefetch buffer.
//
// A pc walks instruction memory, pushing {address, word} pairs into a
// two-entry FIFO whenever there is room. The consumer pops the head with an
// ivalid/iready handshake. A jmp redirects the pc and flushes the buffer.
//
// Parameters
//   aw : instruction memory address width (default 8)
//   dw : instruction word width (default 16)
//
// Ports
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : ifetch_if.master (addr/rex/rdata memory port, instr/iaddr/ivalid/
//         iready consumer stream, jmp/jaddr redirect, halted flag)
//
// Configuration
//   IFETCH_HALT_EN : when defined, fetching an all-ones word buffers it and
//                    then stops fetching until jmp or rst. When undefined,
//                    halted is tied low and the all-ones word is ordinary.
// ----------------------------------------------------------------------------
module ifetch #(
    parameter int aw = 8,
    parameter int dw = 16
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    logic [aw-1:0] pc_q, pc_d;
    logic [1:0]    count_q, count_d;
    // Entry 0 is always the head; entry 1 only meaningful when count is 2.
    logic [aw-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [dw-1:0] word0_q, word0_d, word1_q, word1_d;

    logic fetch;
    logic pop;
    logic halted_w;

`ifdef IFETCH_HALT_EN
    logic halted_q, halted_d;
    assign halted_w = halted_q;
`else
    assign halted_w = 1'b0;
`endif

    assign fetch = (count_q != 2'd2) && !bus.jmp && !halted_w && !rst;
    assign pop   = (count_q != 2'd0) && bus.iready;

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        addr0_d = addr0_q;
        addr1_d = addr1_q;
        word0_d = word0_q;
        word1_d = word1_q;
        if (bus.jmp) begin
            // A pop this cycle is simply consumed; everything else is flushed.
            pc_d    = bus.jaddr;
            count_d = 2'd0;
        end else begin
            // Only shift the second entry forward when it holds real data, so
            // instr/iaddr keep their last values once the buffer drains.
            if (pop && (count_q == 2'd2)) begin
                addr0_d = addr1_q;
                word0_d = word1_q;
            end
            if (fetch) begin
                if ((count_q == 2'd0) || pop) begin
                    addr0_d = pc_q;
                    word0_d = bus.rdata;
                end else begin
                    addr1_d = pc_q;
                    word1_d = bus.rdata;
                end
                pc_d = pc_q + 1'b1;
            end
            count_d = count_q + {1'b0, fetch} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            count_q <= 2'd0;
            addr0_q <= '0;
            addr1_q <= '0;
            word0_q <= '0;
            word1_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
        end
    end

`ifdef IFETCH_HALT_EN
    // The halting word itself is buffered normally; only later fetches stop.
    always_comb begin
        halted_d = halted_q;
        if (bus.jmp) begin
            halted_d = 1'b0;
        end else if (fetch && (bus.rdata == {dw{1'b1}})) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`endif

    assign bus.addr   = pc_q;
    assign bus.rex    = !fetch;
    assign bus.instr  = word0_q;
    assign bus.iaddr  = addr0_q;
    assign bus.ivalid = (count_q != 2'd0);
    assign bus.halted = halted_w;

endmodule

// File: tb/tb_ifetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch.
//
// A queue-based reference model tracks the prefetch buffer, pc and halted
// flag; DUT outputs are compared against it every cycle, half a cycle away
// from the active edge. Directed scenarios are followed by a random phase.
// Honours IFETCH_HALT_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_ifetch;

    logic clk;
    logic rst;

    ifetch_if #(.aw(8), .dw(16)) bus ();

    ifetch #(.aw(8), .dw(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [256];

    assign bus.rdata = mem[bus.addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] w;
    } entry_t;

    entry_t     mq[$];
    logic [7:0] mPc;
    logic       mHalted;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input logic r, input logic j);
        logic expFetch;
        expFetch = (mq.size() < 2) && !j && !mHalted && !r;
        check("rex", {31'b0, bus.rex}, {31'b0, !expFetch});
        check("addr", {24'b0, bus.addr}, {24'b0, mPc});
        check("ivalid", {31'b0, bus.ivalid}, {31'b0, (mq.size() != 0)});
        check("halted", {31'b0, bus.halted}, {31'b0, mHalted});
        if (mq.size() != 0) begin
            check("iaddr", {24'b0, bus.iaddr}, {24'b0, mq[0].a});
            check("instr", {16'b0, bus.instr}, {16'b0, mq[0].w});
        end
    endtask

    // Reference behaviour at a clock edge, from the buffer rules directly.
    task automatic updateModel(input logic r, input logic j, input logic ir, input logic [7:0] ja);
        logic   doFetch;
        logic   doPop;
        entry_t e;
        doFetch = (mq.size() < 2) && !j && !mHalted && !r;
        doPop   = (mq.size() > 0) && ir;
        if (r) begin
            mq.delete();
            mPc     = 8'h00;
            mHalted = 1'b0;
        end else if (j) begin
            mq.delete();
            mPc     = ja;
            mHalted = 1'b0;
        end else begin
            if (doPop) void'(mq.pop_front());
            if (doFetch) begin
                e.a = mPc;
                e.w = mem[mPc];
                mq.push_back(e);
`ifdef IFETCH_HALT_EN
                if (mem[mPc] == 16'hFFFF) mHalted = 1'b1;
`endif
                mPc = mPc + 8'd1;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic j, input logic ir, input logic [7:0] ja);
        rst        = r;
        bus.jmp    = j;
        bus.iready = ir;
        bus.jaddr  = ja;
        #1;
        checkOutput(r, j);
        @(posedge clk);
        updateModel(r, j, ir, ja);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        mPc        = 8'h00;
        mHalted    = 1'b0;
        rst        = 1'b1;
        bus.jmp    = 1'b0;
        bus.iready = 1'b0;
        bus.jaddr  = 8'h00;
        @(posedge clk);
        @(negedge clk);

        // Reset, then free-run with mem[i]=i
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Back-pressure from reset
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check("bp_pc_frozen", {24'b0, bus.addr}, 32'h2);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Address wrap
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFE);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Redirect with a full buffer holding 5 and 6
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h05);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h40);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        check("redir_iaddr", {24'b0, bus.iaddr}, 32'h40);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Reset mid-operation with a full buffer
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Halt word at address 3
        mem[3] = 16'hFFFF;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
`ifdef IFETCH_HALT_EN
        check("halt_pc", {24'b0, bus.addr}, 32'h4);
`else
        check("nohalt_pc", {24'b0, bus.addr}, 32'h8);
`endif
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Random phase
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
        mem[8'($urandom_range(0, 255))] = 16'hFFFF;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
